// File: rtl/knight_scan.sv
// knight_scan: prescaled lamp scanner with bounce/wrap head motion and an optional trail of past positions
module knight_scan #(
  parameter int WIDTH = 8,
  parameter int DIV = 1,
  parameter int TRAIL = 0
) (
  input  logic                     ck,
  input  logic                     res,
  input  logic                     en,
  input  logic                     mode,
  output logic [WIDTH-1:0]         out,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic                     dir,
  output logic                     tick
);
  localparam int PW = $clog2(WIDTH);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(WIDTH - 1);
  localparam logic [CW-1:0] CMAX = CW'(DIV - 1);
  logic [CW-1:0] cnt;
  logic step, nxt_dir;
  logic [PW-1:0] nxt_pos, fwd, bwd;
  logic [WIDTH-1:0] trail_mask;
  always_comb begin
    step = en && cnt == CMAX;
    fwd = pos == LAST ? '0 : pos + 1'b1;
    bwd = pos == '0 ? LAST : pos - 1'b1;
    nxt_dir = mode ? dir : (dir ? pos != '0 : pos == LAST);
    nxt_pos = mode ? (dir ? bwd : fwd) : (nxt_dir ? pos - 1'b1 : pos + 1'b1);
  end
  always_ff @(posedge ck)
    if (!res) begin
      cnt <= '0;
      pos <= '0;
      dir <= 1'b0;
      tick <= 1'b0;
    end else begin
      tick <= step;
      if (en) cnt <= step ? '0 : cnt + 1'b1;
      if (step) begin
        pos <= nxt_pos;
        dir <= nxt_dir;
      end
    end
  if (TRAIL > 0) begin : g_trail
    logic [PW-1:0] hist [TRAIL];
    always_ff @(posedge ck)
      if (!res) hist <= '{default: '0};
      else if (step) begin
        hist[0] <= pos;
        for (int i = 1; i < TRAIL; i++) hist[i] <= hist[i-1];
      end
    always_comb begin
      trail_mask = '0;
      for (int i = 0; i < TRAIL; i++) trail_mask = trail_mask | (WIDTH'(1) << hist[i]);
    end
  end else begin : g_none
    assign trail_mask = '0;
  end
  assign out = (WIDTH'(1) << pos) | trail_mask;
endmodule
